// File: rtl/rr_stream_mux_pkg.sv
// rr_stream_mux_pkg: shared constants, lock state type and index-width helper
package rr_stream_mux_pkg;
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    typedef enum logic {IDLE, LOCKED} lock_state_t;

    // Index width for n channels, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter (rotate, priority-encode, rotate back)
//   req      in   N    requests
//   last_idx in   IW   most recently granted index; scan starts just after it
//   gnt      out  N    one-hot grant, zero when no request
//   gnt_idx  out  IW   index of the granted request
//   any      out  1    at least one request present
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter int N = 8,
    localparam int IW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  start;
    logic [IW-1:0]  k;
    logic [IW:0]    sum;

    always_comb begin
        start = (last_idx == IW'(N - 1)) ? '0 : last_idx + 1'b1;
        // Rotating via a doubled vector puts channel 'start' at bit 0.
        dbl = {req, req} >> start;
        rot = dbl[N-1:0];
        k = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) k = IW'(i);
        sum = {1'b0, start} + {1'b0, k};
        gnt_idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
        any = |req;
        gnt = any ? (N'(1) << gnt_idx) : '0;
    end
endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N_CH:1 valid/ready stream mux, round-robin or fixed select, registered output
//   clk, rst_n (async active-low)
//   mode (0 round-robin, 1 fixed), sel (fixed channel; >= N_CH grants nothing)
//   in_data/in_valid/in_ready  per-channel input streams
//   out_data/out_ch/out_valid/out_ready  registered output stream with source index
//   RR_STREAM_MUX_LAST_EN adds in_last/out_last and locks the grant to a channel until its last beat
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int DATA_W = 8,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
`ifdef RR_STREAM_MUX_LAST_EN
    input  logic [N_CH-1:0]        in_last,
    output logic                   out_last,
`endif
    input  logic                   out_ready
);
    logic [SEL_W-1:0]  last;
    logic [N_CH-1:0]   rr_gnt;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_any;
    logic [N_CH-1:0]   fx_gnt;
    logic [N_CH-1:0]   gnt;
    logic [SEL_W-1:0]  idx;
    logic [DATA_W-1:0] sel_data;
    logic              free;
    logic              xfer;

    rr_arbiter #(.N(N_CH)) u_arb (
        .req      (in_valid),
        .last_idx (last),
        .gnt      (rr_gnt),
        .gnt_idx  (rr_idx),
        .any      (rr_any)
    );

    // An out-of-range sel shifts the one-hot past the top bit, granting nothing.
    assign fx_gnt = (N_CH'(1) << sel) & in_valid;

`ifdef RR_STREAM_MUX_LAST_EN
    lock_state_t state, state_n;

    // While locked, the locked channel is always 'last' (pointer follows every accepted beat).
    always_comb begin
        gnt = (mode == MODE_FIXED) ? fx_gnt : (rr_any ? rr_gnt : '0);
        idx = (mode == MODE_FIXED) ? sel : rr_idx;
        if (state == LOCKED) begin
            gnt = (N_CH'(1) << last) & in_valid;
            idx = last;
        end
    end

    always_comb begin
        state_n = state;
        if (xfer) state_n = |(in_last & gnt) ? IDLE : LOCKED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_last <= 1'b0;
        end else begin
            state <= state_n;
            if (xfer) out_last <= |(in_last & gnt);
        end
    end
`else
    always_comb begin
        gnt = (mode == MODE_FIXED) ? fx_gnt : (rr_any ? rr_gnt : '0);
        idx = (mode == MODE_FIXED) ? sel : rr_idx;
    end
`endif

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++)
            if (gnt[i]) sel_data = in_data[i*DATA_W +: DATA_W];
    end

    assign free     = ~out_valid | out_ready;
    assign in_ready = gnt & {N_CH{free}};
    assign xfer     = |in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            last      <= SEL_W'(N_CH - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= idx;
            last      <= idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: self-checking bench for rr_stream_mux (directed scenarios plus randomized model check)
module tb_rr_stream_mux;
    localparam int N = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode = 1'b0;
    logic [2:0]    sel = '0;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]  in_valid = '0;
    logic [N-1:0]  in_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    out_ch;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  in_last = '0;
    logic          out_last;

    // Five-channel instance: the only way to present sel values >= N_CH.
    logic [3:0]    sel5 = '0;
    logic [5*DW-1:0] in_data5 = '0;
    logic [4:0]    in_valid5 = '0;
    logic [4:0]    in_ready5;
    logic [DW-1:0] out_data5;
    logic [2:0]    out_ch5;
    logic          out_valid5;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit     m_valid;
    int     m_data;
    int     m_ch;
    int     m_last;
    bit     m_locked;
    int     m_lock_ch;
    bit     m_olast;

    always #5 clk = ~clk;

    rr_stream_mux #(.N_CH(N), .DATA_W(DW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
`ifdef RR_STREAM_MUX_LAST_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_ready (out_ready)
    );

`ifndef RR_STREAM_MUX_LAST_EN
    assign out_last = 1'b0;
`endif

    rr_stream_mux #(.N_CH(5), .DATA_W(DW)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (1'b1),
        .sel       (sel5[2:0]),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .out_data  (out_data5),
        .out_ch    (out_ch5),
        .out_valid (out_valid5),
`ifdef RR_STREAM_MUX_LAST_EN
        .in_last   (5'b11111),
        .out_last  (),
`endif
        .out_ready (1'b1)
    );

    // Channel the specification's rules grant this cycle, or -1.
    function automatic int exp_grant();
        if (m_valid && !out_ready) return -1;
        if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (mode) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 1; k <= N; k++)
            if (in_valid[(m_last + k) % N]) return (m_last + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_ch = 0; m_last = N - 1;
        m_locked = 0; m_lock_ch = 0; m_olast = 0;
    endtask

    // Advance one clock and let the model follow the transfer rules.
    task automatic tick();
        int g;
        g = exp_grant();
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1;
            m_data = int'(in_data[g*DW +: DW]);
            m_ch = g;
            m_last = g;
`ifdef RR_STREAM_MUX_LAST_EN
            m_locked = !in_last[g];
            m_lock_ch = g;
            m_olast = in_last[g];
`endif
        end else if (out_ready) m_valid = 0;
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        mode = 0; sel = 0; in_valid = '0; in_last = '0; out_ready = 0;
        in_valid5 = '0; sel5 = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1; #1;
    endtask

    function automatic logic [DW-1:0] rnd8();
        return DW'($urandom_range(0, 255));
    endfunction

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%0h want=0", out_data); end
        n_cmp++; if (out_ch !== 3'd0) begin n_err++; $display("FAIL reset_ch got=%0d want=0", out_ch); end
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = rnd8();
        in_valid = 8'hF0; out_ready = 0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL prereset_valid got=%0b want=1", out_valid); end
        rst_n = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_valid got=%0b want=0", out_valid); end
        model_reset();
        #2 rst_n = 1'b1;
        in_valid = 8'hFF; out_ready = 1; #1;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_ch !== 3'd0) begin n_err++; $display("FAIL first_grant got v=%0b ch=%0d want v=1 ch=0", out_valid, out_ch); end
    endtask

    task automatic test_rr_fairness();
        do_reset();
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = rnd8();
        in_valid = 8'hFF; out_ready = 1;
        for (int k = 0; k <= N; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_ch !== 3'(k % N) || out_data !== in_data[(k % N)*DW +: DW]) begin
                n_err++;
                $display("FAIL rr_seq[%0d] got v=%0b ch=%0d d=%0h want v=1 ch=%0d d=%0h", k, out_valid, out_ch, out_data, k % N, in_data[(k % N)*DW +: DW]);
            end
        end
    endtask

    task automatic test_backpressure();
        int beats;
        do_reset();
        in_data[3*DW +: DW] = 8'hA5; in_valid = 8'h08; out_ready = 0;
        tick();
        in_valid = '0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 8'hFF; #1;
            n_cmp++; if (in_ready !== 8'h00) begin n_err++; $display("FAIL bp_ready[%0d] got=%0h want=0", k, in_ready); end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 3'd3) begin
                n_err++; $display("FAIL bp_hold[%0d] got v=%0b d=%0h ch=%0d want v=1 d=a5 ch=3", k, out_valid, out_data, out_ch);
            end
        end
        in_valid = '0; out_ready = 1; beats = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid && out_ready) beats++;
            tick();
        end
        n_cmp++; if (beats != 1) begin n_err++; $display("FAIL bp_beats got=%0d want=1", beats); end
    endtask

    task automatic test_fixed();
        do_reset();
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = rnd8();
        mode = 1; sel = 3'd5; in_valid = 8'h24; out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (in_ready !== 8'h20) begin n_err++; $display("FAIL fixed_ready[%0d] got=%0h want=20", k, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_ch !== 3'd5) begin n_err++; $display("FAIL fixed_ch[%0d] got v=%0b ch=%0d want v=1 ch=5", k, out_valid, out_ch); end
        end
        for (int i = 0; i < 5; i++) in_data5[i*DW +: DW] = rnd8();
        in_valid5 = 5'h1F; sel5 = 4'd6;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (in_ready5 !== 5'h00) begin n_err++; $display("FAIL sel_oor_ready[%0d] got=%0h want=0", k, in_ready5); end
            tick();
            n_cmp++; if (out_valid5 !== 1'b0) begin n_err++; $display("FAIL sel_oor_valid[%0d] got=%0b want=0", k, out_valid5); end
        end
        sel5 = 4'd4;
        tick();
        n_cmp++; if (out_valid5 !== 1'b1 || out_ch5 !== 3'd4) begin n_err++; $display("FAIL sel_change got v=%0b ch=%0d want v=1 ch=4", out_valid5, out_ch5); end
        in_valid5 = '0;
    endtask

    task automatic test_wrap_skip();
        do_reset();
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = rnd8();
        out_ready = 1; in_valid = 8'h40;
        tick();
        n_cmp++; if (out_ch !== 3'd6) begin n_err++; $display("FAIL wrap_setup got ch=%0d want 6", out_ch); end
        in_valid = 8'h82;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_ch !== 3'd7) begin n_err++; $display("FAIL wrap_first got v=%0b ch=%0d want v=1 ch=7", out_valid, out_ch); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_ch !== 3'd1) begin n_err++; $display("FAIL wrap_second got v=%0b ch=%0d want v=1 ch=1", out_valid, out_ch); end
    endtask

`ifdef RR_STREAM_MUX_LAST_EN
    task automatic test_packet();
        int want_ch[4] = '{2, 2, 2, 4};
        bit want_last[4] = '{0, 0, 1, 1};
        do_reset();
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = rnd8();
        out_ready = 1; in_last = 8'h10;
        for (int k = 0; k < 4; k++) begin
            in_valid = (k < 3) ? 8'h14 : 8'h10;
            if (k == 1) in_valid = 8'h10;
            in_last[2] = (k == 2);
            #1;
            if (k == 1) begin
                n_cmp++; if (in_ready !== 8'h00) begin n_err++; $display("FAIL pkt_lock_hold got=%0h want=0", in_ready); end
                tick();
                in_valid = 8'h14; #1;
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_ch !== 3'(want_ch[k]) || out_last !== want_last[k]) begin
                n_err++; $display("FAIL pkt_beat[%0d] got ch=%0d last=%0b want ch=%0d last=%0b", k, out_ch, out_last, want_ch[k], want_last[k]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int g;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) in_data[i*DW +: DW] = rnd8();
            in_valid = N'($urandom);
            in_last = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel = 3'($urandom);
            #1;
            g = exp_grant();
            n_cmp++;
            if (in_ready !== ((g >= 0) ? (N'(1) << g) : N'(0))) begin
                n_err++; $display("FAIL rnd_ready[%0d] got=%0h want_ch=%0d", c, in_ready, g);
            end
            tick();
            n_cmp++;
            if (out_valid !== m_valid || (m_valid && (out_data !== DW'(m_data) || out_ch !== 3'(m_ch) || out_last !== m_olast))) begin
                n_err++; $display("FAIL rnd_out[%0d] got v=%0b d=%0h ch=%0d l=%0b want v=%0b d=%0h ch=%0d l=%0b",
                                  c, out_valid, out_data, out_ch, out_last, m_valid, m_data, m_ch, m_olast);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rr_fairness();
        test_backpressure();
        test_fixed();
        test_wrap_skip();
`ifdef RR_STREAM_MUX_LAST_EN
        test_packet();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
